// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between two pipeline stages.
// The producer drives valid/data through master; the consumer drives ready through slave.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 128
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage pipeline buffer: DEPTH-entry circular store with valid/ready handshake,
// flush, and a saturating count of entries discarded by flush.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  pipe_stage_buf_if.slave              in_if,
  pipe_stage_buf_if.master             out_if,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DropMax = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [31:0]       drop_sum;
  logic              in_ready, out_valid, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign push      = in_if.valid & in_ready & ~flush_i;
  assign pop       = out_valid & out_if.ready & ~flush_i;

  generate
    if (DEPTH == 1) begin : g_single
      // Stage-register behaviour: a pop frees the slot within the same cycle.
      assign in_ready    = ~out_valid | out_if.ready;
      assign out_if.data = mem_q[0];

      always_ff @(posedge clk_i) begin
        if (!rst_ni)   mem_q[0] <= '0;
        else if (push) mem_q[0] <= in_if.data;
      end
    end else begin : g_multi
      // Depends on registered count only, so out_ready never reaches in_ready.
      assign in_ready    = (count_q < CntW'(DEPTH));
      assign out_if.data = mem_q[rd_ptr_q];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
          mem_q[wr_ptr_q] <= in_if.data;
        end
      end
    end
  endgenerate

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign count_o      = count_q;
  assign drop_cnt_o   = drop_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    drop_sum = 32'(drop_q) + 32'(count_q);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = (drop_sum > DropMax) ? CNT_W'(DropMax) : CNT_W'(drop_sum);
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 (A), DEPTH=1 (B), DEPTH=3 with 2-bit drop counter (C).
module tb_pipe_stage_buf;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic a_flush, b_flush, c_flush;
  logic [1:0] a_count, c_count;
  logic [0:0] b_count;
  logic [7:0] a_drop, b_drop;
  logic [1:0] c_drop;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_buf_if #(.DATA_W(16)) a_in  ();
  pipe_stage_buf_if #(.DATA_W(16)) a_out ();
  pipe_stage_buf_if #(.DATA_W(16)) b_in  ();
  pipe_stage_buf_if #(.DATA_W(16)) b_out ();
  pipe_stage_buf_if #(.DATA_W(16)) c_in  ();
  pipe_stage_buf_if #(.DATA_W(16)) c_out ();

  pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .CNT_W(8)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_if(a_in), .out_if(a_out),
    .flush_i(a_flush), .count_o(a_count), .drop_cnt_o(a_drop)
  );
  pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .CNT_W(8)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_if(b_in), .out_if(b_out),
    .flush_i(b_flush), .count_o(b_count), .drop_cnt_o(b_drop)
  );
  pipe_stage_buf #(.DATA_W(16), .DEPTH(3), .CNT_W(2)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_if(c_in), .out_if(c_out),
    .flush_i(c_flush), .count_o(c_count), .drop_cnt_o(c_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int sent, received;
    rst_ni = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
    a_in.valid = 1'b1; a_in.data = 16'h00AA; a_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 16'h00BB; b_out.ready = 1'b0;
    c_in.valid = 1'b1; c_in.data = 16'h00CC; c_out.ready = 1'b0;
    tick();
    tick();
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_valid", 32'(a_out.valid), 0);
    chk("rst_a_data", 32'(a_out.data), 0);
    chk("rst_a_drop", 32'(a_drop), 0);
    chk("rst_b_count", 32'(b_count), 0);
    chk("rst_b_valid", 32'(b_out.valid), 0);
    chk("rst_c_count", 32'(c_count), 0);
    chk("rst_c_drop", 32'(c_drop), 0);
    rst_ni = 1'b1;
    a_in.valid = 1'b0; b_in.valid = 1'b0; c_in.valid = 1'b0;
    tick();

    // Streaming through DEPTH=2
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.data = 16'h0011;
    #1 chk("str_in_ready", 32'(a_in.ready), 1);
    tick();
    chk("str_d1", 32'(a_out.data), 32'h11);
    chk("str_v1", 32'(a_out.valid), 1);
    chk("str_c1", 32'(a_count), 1);
    a_in.data = 16'h0022;
    tick();
    chk("str_d2", 32'(a_out.data), 32'h22);
    chk("str_c2", 32'(a_count), 1);
    a_in.data = 16'h0033;
    tick();
    chk("str_d3", 32'(a_out.data), 32'h33);
    chk("str_c3", 32'(a_count), 1);
    a_in.valid = 1'b0;
    tick();
    chk("str_empty_v", 32'(a_out.valid), 0);
    chk("str_empty_c", 32'(a_count), 0);

    // Fill and stall DEPTH=2
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 16'h000A;
    tick();
    a_in.data = 16'h000B;
    tick();
    chk("fill_c2", 32'(a_count), 2);
    chk("fill_ready0", 32'(a_in.ready), 0);
    a_in.data = 16'h000C;
    tick();
    chk("fill_refuse_c", 32'(a_count), 2);
    chk("fill_stall_d", 32'(a_out.data), 32'hA);
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    #1 chk("fill_no_comb", 32'(a_in.ready), 0);
    tick();
    chk("drain_d1", 32'(a_out.data), 32'hB);
    chk("drain_c1", 32'(a_count), 1);
    chk("drain_ready1", 32'(a_in.ready), 1);
    tick();
    chk("drain_v0", 32'(a_out.valid), 0);
    a_out.ready = 1'b0;

    // Flush with two held entries, concurrent input and pop attempt
    a_in.valid = 1'b1; a_in.data = 16'h0001;
    tick();
    a_in.data = 16'h0002;
    tick();
    chk("fl_pre_c", 32'(a_count), 2);
    a_in.data = 16'h0003; a_flush = 1'b1; a_out.ready = 1'b1;
    tick();
    a_flush = 1'b0; a_in.valid = 1'b0;
    chk("fl_c0", 32'(a_count), 0);
    chk("fl_v0", 32'(a_out.valid), 0);
    chk("fl_drop2", 32'(a_drop), 2);
    tick();
    chk("fl_in_dropped", 32'(a_count), 0);
    a_out.ready = 1'b0;

    // DEPTH=1 pass-through
    b_in.valid = 1'b1; b_in.data = 16'h0005;
    tick();
    chk("p1_d5", 32'(b_out.data), 5);
    chk("p1_c1", 32'(b_count), 1);
    chk("p1_ready0", 32'(b_in.ready), 0);
    b_out.ready = 1'b1; b_in.data = 16'h0006;
    #1 chk("p1_ready_comb", 32'(b_in.ready), 1);
    tick();
    chk("p1_d6", 32'(b_out.data), 6);
    chk("p1_v1", 32'(b_out.valid), 1);
    chk("p1_c_stay", 32'(b_count), 1);
    b_in.valid = 1'b0;
    tick();
    chk("p1_empty", 32'(b_out.valid), 0);

    // Drop counter saturation with CNT_W=2
    c_in.valid = 1'b1; c_in.data = 16'h0050;
    tick();
    tick();
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    chk("sat_drop2", 32'(c_drop), 2);
    tick();
    tick();
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    chk("sat_drop3", 32'(c_drop), 3);
    tick();
    c_flush = 1'b1; c_in.valid = 1'b0;
    tick();
    c_flush = 1'b0;
    chk("sat_hold3", 32'(c_drop), 3);
    chk("sat_c0", 32'(c_count), 0);

    // Pointer wrap on DEPTH=3 with random backpressure
    sent = 0;
    received = 0;
    for (int cyc = 0; cyc < 300 && received < 10; cyc++) begin
      c_in.valid = (sent < 10);
      c_in.data = 16'h0100 + 16'(sent);
      c_out.ready = 1'($urandom_range(0, 1));
      #1;
      if (c_out.valid && c_out.ready) begin
        chk("wrap_order", 32'(c_out.data), 32'h100 + 32'(received));
        received++;
      end
      if (c_in.valid && c_in.ready) sent++;
      tick();
    end
    chk("wrap_all_received", 32'(received), 10);
    c_in.valid = 1'b0;
    c_out.ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
